// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline types and constants
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pipe_state_t;

  localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use hazard detect between ID/EX and IF/ID
module hazard_unit
  import cpu_types_pkg::*;
(
  input  logic     exMemRead,
  input  regbits_t exwsel,
  input  regbits_t idrs,
  input  regbits_t idrt,
  output logic     load_use
);

  // Writes to $0 are discarded, so they can never create a dependency.
  assign load_use = exMemRead && (exwsel != REG_ZERO) &&
                    ((exwsel == idrs) || (exwsel == idrt));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush sequencing and perf counters
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             memREN,
  input  logic             memWEN,
  input  logic             exMemRead,
  input  logic [4:0]       exwsel,
  input  logic [4:0]       idrs,
  input  logic [4:0]       idrt,
  input  logic             idJump,
  input  logic             exBranchTaken,
  input  logic             idHALT,
  input  logic             wbcuHALT,
  output logic             pcW,
  output logic             ifidW,
  output logic             idexW,
  output logic             exmemW,
  output logic             memW,
  output logic             ifidRST,
  output logic             idexRST,
  output logic             exmemRST,
  output logic             memRST,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_t state;
  logic        load_use;
  logic        dmem_pend;
  logic        draining;

  hazard_unit u_hazard (
    .exMemRead (exMemRead),
    .exwsel    (exwsel),
    .idrs      (idrs),
    .idrt      (idrt),
    .load_use  (load_use)
  );

  assign dmem_pend = (memREN | memWEN) & ~dhit;
  assign draining  = (state == DRAIN);

  always_comb begin
    pcW      = 1'b0;
    ifidW    = 1'b0;
    idexW    = 1'b0;
    exmemW   = 1'b0;
    memW     = 1'b0;
    ifidRST  = 1'b0;
    idexRST  = 1'b0;
    exmemRST = 1'b0;
    memRST   = 1'b0;
    if (RST || state == HALTED) begin
      // everything frozen
    end else if (dmem_pend) begin
      memRST  = 1'b1;
      ifidRST = draining;
    end else begin
      pcW    = 1'b1;
      ifidW  = 1'b1;
      idexW  = 1'b1;
      exmemW = 1'b1;
      memW   = 1'b1;
      if (exBranchTaken) begin
        ifidRST = 1'b1;
        idexRST = 1'b1;
      end else if (load_use) begin
        pcW     = 1'b0;
        ifidW   = 1'b0;
        idexRST = 1'b1;
      end else if (!draining && idJump) begin
        ifidRST = 1'b1;
      end else if (!draining && !ihit) begin
        pcW     = 1'b0;
        ifidRST = 1'b1;
      end
      // While draining, fetch stays frozen and IF/ID keeps receiving bubbles.
      if (draining) begin
        pcW     = 1'b0;
        ifidRST = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      halt      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (wbcuHALT) begin
        state <= HALTED;
        halt  <= 1'b1;
      end else begin
        case (state)
          RUN:     if (dmem_pend) state <= DWAIT;
                   else if (idHALT) state <= DRAIN;
          DWAIT:   if (!dmem_pend) state <= RUN;
          DRAIN:   if (!dmem_pend && exBranchTaken) state <= RUN;
          default: state <= HALTED;
        endcase
      end
      if (!pcW && state != HALTED && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((ifidRST || idexRST) && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  localparam int CW = 3;
  localparam logic [CW-1:0] CMAX = '1;

  localparam logic [8:0] S_N    = 9'b11111_0000;
  localparam logic [8:0] S_LU   = 9'b00111_0100;
  localparam logic [8:0] S_NOI  = 9'b01111_1000;
  localparam logic [8:0] S_JMP  = 9'b11111_1000;
  localparam logic [8:0] S_DW   = 9'b00000_0001;
  localparam logic [8:0] S_BR   = 9'b11111_1100;
  localparam logic [8:0] S_DR   = 9'b01111_1000;
  localparam logic [8:0] S_DRBR = 9'b01111_1100;
  localparam logic [8:0] S_DRDW = 9'b00000_1001;
  localparam logic [8:0] S_Z    = 9'b00000_0000;

  logic CLK = 1'b0;
  logic RST;
  logic ihit, dhit, memREN, memWEN, exMemRead, idJump, exBranchTaken, idHALT, wbcuHALT;
  logic [4:0] exwsel, idrs, idrt;
  logic pcW, ifidW, idexW, exmemW, memW, ifidRST, idexRST, exmemRST, memRST, halt;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0] strb;

  int total = 0;
  int bad = 0;
  pipe_state_t es;
  logic [CW-1:0] exp_stall, exp_flush;
  logic exp_halt;

  always #5 CLK = ~CLK;

  assign strb = {pcW, ifidW, idexW, exmemW, memW, ifidRST, idexRST, exmemRST, memRST};

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .memREN(memREN), .memWEN(memWEN),
    .exMemRead(exMemRead), .exwsel(exwsel), .idrs(idrs), .idrt(idrt), .idJump(idJump),
    .exBranchTaken(exBranchTaken), .idHALT(idHALT), .wbcuHALT(wbcuHALT),
    .pcW(pcW), .ifidW(ifidW), .idexW(idexW), .exmemW(exmemW), .memW(memW),
    .ifidRST(ifidRST), .idexRST(idexRST), .exmemRST(exmemRST), .memRST(memRST),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_state"}, 32'(dut.state), 32'(es));
    chk({tag, "_halt"}, 32'(halt), 32'(exp_halt));
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, "_flush"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  // Inputs are already applied; check strobes, clock once, check registered state.
  task automatic step(input string tag, input logic [8:0] ev, input pipe_state_t ns);
    #1;
    chk({tag, "_strb"}, 32'(strb), 32'(ev));
    if (es != HALTED && !ev[8] && exp_stall != CMAX) exp_stall = exp_stall + 1'b1;
    if ((ev[3] || ev[2]) && exp_flush != CMAX) exp_flush = exp_flush + 1'b1;
    es = ns;
    if (ns == HALTED) exp_halt = 1'b1;
    @(posedge CLK);
    #1;
    chk_regs(tag);
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; memREN = 1'b0; memWEN = 1'b0;
    exMemRead = 1'b0; exwsel = 5'd0; idrs = 5'd0; idrt = 5'd0;
    idJump = 1'b0; exBranchTaken = 1'b0; idHALT = 1'b0; wbcuHALT = 1'b0;
  endtask

  task automatic clear_model();
    es = RUN; exp_stall = '0; exp_flush = '0; exp_halt = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    clear_model();
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    chk("rst_strb", 32'(strb), 32'(S_Z));
    chk_regs("rst");
    @(posedge CLK); #1;
    RST = 1'b0;

    step("normal", S_N, RUN);
    exMemRead = 1'b1; exwsel = 5'd0; idrs = 5'd0;
    step("zero_dest", S_N, RUN);
    exwsel = 5'd3; idrs = 5'd3; idrt = 5'd5;
    step("lu_rs", S_LU, RUN);
    exMemRead = 1'b0;
    step("lu_after", S_N, RUN);
    exMemRead = 1'b1; exwsel = 5'd5; idrs = 5'd4; idrt = 5'd5;
    step("lu_rt", S_LU, RUN);
    exMemRead = 1'b0; ihit = 1'b0;
    step("imiss", S_NOI, RUN);
    ihit = 1'b1; idJump = 1'b1;
    step("jump", S_JMP, RUN);
    idJump = 1'b0; memREN = 1'b1; dhit = 1'b1;
    step("dhit_same", S_N, RUN);
    dhit = 1'b0;
    step("dwait1", S_DW, DWAIT);
    step("dwait2", S_DW, DWAIT);
    step("dwait3", S_DW, DWAIT);
    dhit = 1'b1;
    step("dwait_done", S_N, RUN);
    memREN = 1'b0; dhit = 1'b0;
    exBranchTaken = 1'b1; exMemRead = 1'b1; exwsel = 5'd3; idrs = 5'd3;
    step("br_lu", S_BR, RUN);
    memWEN = 1'b1;
    step("dw_over_br", S_DW, DWAIT);
    idle_inputs();
    step("dwait_exit", S_N, RUN);

    idHALT = 1'b1;
    step("halt_dec", S_N, DRAIN);
    idHALT = 1'b0; exBranchTaken = 1'b1;
    step("drain_cancel", S_DRBR, RUN);
    exBranchTaken = 1'b0; idHALT = 1'b1;
    step("halt_dec2", S_N, DRAIN);
    idHALT = 1'b0;
    for (int i = 0; i < 4; i++) step("drain", S_DR, DRAIN);
    wbcuHALT = 1'b1; memREN = 1'b1;
    step("halt_wins", S_DRDW, HALTED);
    wbcuHALT = 1'b0; memREN = 1'b0; ihit = 1'b0; exBranchTaken = 1'b1;
    step("halted1", S_Z, HALTED);
    step("halted2", S_Z, HALTED);

    RST = 1'b1;
    idle_inputs();
    clear_model();
    #1;
    chk("rst2_strb", 32'(strb), 32'(S_Z));
    chk_regs("rst2");
    @(posedge CLK); #1;
    RST = 1'b0;
    memREN = 1'b1;
    for (int i = 0; i < 5; i++) step("dwait5", S_DW, DWAIT);
    chk("stall_is5", 32'(stall_cnt), 32'd5);
    RST = 1'b1;
    clear_model();
    #1;
    chk("rst3_strb", 32'(strb), 32'(S_Z));
    chk_regs("rst3");
    @(posedge CLK); #1;
    RST = 1'b0;
    idle_inputs();
    step("post_rst", S_N, RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
